// File: rtl/rle_decompressor_if.sv
// ---------------------------------------------------------------------------
// rle_decompressor_if
// Groups the request, token-input and word-output handshakes of the RLE
// decompressor, together with its status flags, into one bundle.
//   master : block requester / token source / memory write port (testbench)
//   slave  : the decompressor itself
// Signals:
//   start, base_addr       - block request and first word address
//   in_valid/in_ready      - compressed token handshake, in_data = {count, value}
//   out_valid/out_ready    - reconstructed word handshake, out_data/out_addr
//   busy, done             - activity and block-complete pulse
//   err_zero, err_ovf      - sticky error flags for the current block
// ---------------------------------------------------------------------------
interface rle_decompressor_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;
  logic              err_zero;
  logic              err_ovf;

  modport master (
    output start, base_addr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr, busy, done, err_zero, err_ovf
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr, busy, done, err_zero, err_ovf
  );
endinterface

// File: rtl/rle_decompressor.sv
// ---------------------------------------------------------------------------
// rle_decompressor
// Rebuilds a block of BLOCK_WORDS 32-bit words from run-length tokens and
// presents each word with its address to a memory write port.
// Ports:
//   clk    - single clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   io_bus - rle_decompressor_if.slave (start/base_addr, token stream,
//            word stream, busy/done, err_zero/err_ovf)
// Tokens carry a 4-bit run count in [31:28] and a 28-bit value in [27:0].
// A zero count is consumed without output and flagged; a run that would
// spill past the end of the block is clipped and flagged.
// ---------------------------------------------------------------------------
module rle_decompressor #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  rle_decompressor_if.slave  io_bus
);

  localparam int IDX_W = $clog2(BLOCK_WORDS + 1);
  // Run arithmetic must hold both a 4-bit token count and a full index
  localparam int CW    = (IDX_W > 4) ? IDX_W : 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_out_addr;
  logic [31:0]       r_out_data;
  logic [IDX_W-1:0]  r_index;
  logic [CW-1:0]     r_run;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_err_zero;
  logic              r_err_ovf;

  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_remaining;
  logic [CW-1:0]     w_take;
  logic [IDX_W-1:0]  w_index_inc;
  logic              w_block_full;

  assign w_count      = CW'(io_bus.in_data[31:28]);
  assign w_remaining  = CW'(BLOCK_WORDS) - CW'(r_index);
  // Clip the run so the block never receives more than BLOCK_WORDS words
  assign w_take       = (w_count > w_remaining) ? w_remaining : w_count;
  assign w_index_inc  = r_index + IDX_W'(1);
  assign w_block_full = (w_index_inc == IDX_W'(BLOCK_WORDS));

  // Single FSM block; every output is a register updated alongside the state
  // so that out_valid/out_data/out_addr stay stable while the writer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_index     <= '0;
      r_run       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_zero  <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_base     <= io_bus.base_addr;
            r_index    <= '0;
            r_err_zero <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= FETCH;
          end
        end

        FETCH: begin
          if (io_bus.in_valid) begin
            if (w_count == '0) begin
              r_err_zero <= 1'b1;
            end else begin
              if (w_count > w_remaining) begin
                r_err_ovf <= 1'b1;
              end
              r_run       <= w_take;
              r_out_data  <= {4'b0000, io_bus.in_data[27:0]};
              r_out_addr  <= r_base + ADDR_W'(r_index);
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
              r_state     <= EMIT;
            end
          end
        end

        EMIT: begin
          if (io_bus.out_ready) begin
            r_index    <= w_index_inc;
            r_run      <= r_run - CW'(1);
            r_out_addr <= r_out_addr + ADDR_W'(1);
            // Last word of this run: either the block is complete or we
            // go back for another token
            if (r_run == CW'(1)) begin
              r_out_valid <= 1'b0;
              if (w_block_full) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_in_ready <= 1'b1;
                r_state    <= FETCH;
              end
            end
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_out_data;
  assign io_bus.out_addr  = r_out_addr;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.err_zero  = r_err_zero;
  assign io_bus.err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_rle_decompressor.sv
// ---------------------------------------------------------------------------
// tb_rle_decompressor
// Self-checking bench for rle_decompressor (BLOCK_WORDS=8, ADDR_W=32).
// A reference model expands a token list into the expected word/address
// sequence and flags; a cycle driver feeds tokens, optionally stalls the
// writer, and records every word transfer for comparison.
// ---------------------------------------------------------------------------
module tb_rle_decompressor;

  localparam int NW = 8;

  logic clk;
  logic rst_n;

  rle_decompressor_if #(.ADDR_W(32)) bus();

  rle_decompressor #(
    .BLOCK_WORDS(NW),
    .ADDR_W     (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus and model results
  logic [31:0] tok_q[$];
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  bit          exp_zero;
  bit          exp_ovf;
  int          exp_used;

  // Observed results from the driver
  logic [31:0] got_data[$];
  logic [31:0] got_addr[$];
  int          got_used;
  int          done_seen;
  int          stab_err;
  int          proto_err;
  bit          timed_out;
  int          first_accept;
  int          first_valid;

  // Driver knobs
  int ready_pct   = 100;
  int valid_pct   = 100;
  bit spam_start  = 1'b0;
  int abort_after = 0;

  // Expand the token list by the block rules: zero counts only flag,
  // runs are clipped at the block end, tokens after the block are unused.
  task automatic model_block(input logic [31:0] base);
    int idx;
    int c;
    int n;
    idx = 0;
    exp_data.delete();
    exp_addr.delete();
    exp_zero = 1'b0;
    exp_ovf  = 1'b0;
    exp_used = 0;
    foreach (tok_q[t]) begin
      if (idx >= NW) break;
      c = int'(tok_q[t][31:28]);
      exp_used++;
      if (c == 0) begin
        exp_zero = 1'b1;
      end else begin
        if (c > NW - idx) begin
          exp_ovf = 1'b1;
          n = NW - idx;
        end else begin
          n = c;
        end
        for (int k = 0; k < n; k++) begin
          exp_data.push_back({4'b0000, tok_q[t][27:0]});
          exp_addr.push_back(base + 32'(idx));
          idx++;
        end
      end
    end
  endtask

  // Random token list that fills a block, plus two spare tokens
  task automatic gen_tokens();
    int idx;
    int c;
    logic [31:0] v;
    tok_q.delete();
    idx = 0;
    while (idx < NW) begin
      c = $urandom_range(0, 15);
      v = $urandom;
      tok_q.push_back({4'(c), v[27:0]});
      if (c > 0) idx += (c > NW - idx) ? (NW - idx) : c;
    end
    tok_q.push_back($urandom);
    tok_q.push_back($urandom);
  endtask

  function automatic int word_mismatches();
    int m;
    m = 0;
    if (got_data.size() != exp_data.size()) return 1000 + got_data.size();
    foreach (exp_data[i]) begin
      if (got_data[i] !== exp_data[i] || got_addr[i] !== exp_addr[i]) m++;
    end
    return m;
  endfunction

  // Start a block and run it cycle by cycle, sampling on the falling edge.
  // Inputs are set first; the handshakes that will complete at the next
  // rising edge are then recorded from the registered DUT outputs.
  task automatic run_block(input logic [31:0] base);
    int ptr;
    int cyc;
    bit stalled;
    logic [31:0] sd;
    logic [31:0] sa;
    ptr = 0;
    cyc = 0;
    stalled = 1'b0;
    sd = '0;
    sa = '0;
    got_data.delete();
    got_addr.delete();
    got_used = 0;
    done_seen = 0;
    stab_err = 0;
    proto_err = 0;
    timed_out = 1'b0;
    first_accept = -1;
    first_valid = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    @(negedge clk);
    bus.start = 1'b0;
    forever begin
      if (bus.done) begin
        done_seen++;
        break;
      end
      if (abort_after > 0 && got_data.size() == abort_after) break;
      if (cyc >= 2000) begin
        timed_out = 1'b1;
        break;
      end
      if (stalled && (!bus.out_valid || bus.out_data !== sd || bus.out_addr !== sa)) stab_err++;
      if (bus.out_valid && bus.in_ready) proto_err++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
      bus.in_valid  = (ptr < tok_q.size()) && ($urandom_range(0, 99) < valid_pct);
      bus.in_data   = (ptr < tok_q.size()) ? tok_q[ptr] : $urandom;
      if (spam_start) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.base_addr = $urandom;
      end
      if (bus.out_valid && bus.out_ready) begin
        got_data.push_back(bus.out_data);
        got_addr.push_back(bus.out_addr);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (first_accept < 0) first_accept = cyc;
        ptr++;
        got_used++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sa = bus.out_addr;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    if (timed_out) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.in_ready, bus.out_valid, bus.done, bus.busy, bus.err_zero, bus.err_ovf} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000",
               {bus.in_ready, bus.out_valid, bus.done, bus.busy, bus.err_zero, bus.err_ovf});
    end
    tests_run++;
    if (bus.out_data !== 32'h0 || bus.out_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_bus: got data %h addr %h expected 0/0", bus.out_data, bus.out_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: got busy %b in_ready %b expected 0 0", bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_single_run();
    int m;
    tok_q = '{{4'd8, 28'd60}};
    model_block(32'h100);
    run_block(32'h100);
    m = word_mismatches();
    tests_run++;
    if (m !== 0) begin
      tests_failed++;
      $display("[TB] FAIL single_words: got %0d words (%0d bad) expected 8 of 60 at 0x100..0x107",
               got_data.size(), m);
    end
    tests_run++;
    if (done_seen !== 1 || bus.err_zero !== 1'b0 || bus.err_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_status: got done %0d zero %b ovf %b expected 1 0 0",
               done_seen, bus.err_zero, bus.err_ovf);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_done_pulse: got done %b busy %b expected 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_multi_token();
    int m;
    logic [31:0] base;
    base = $urandom;
    tok_q = '{{4'd3, 28'd60}, {4'd1, 28'd58}, {4'd4, 28'd62}};
    model_block(base);
    run_block(base);
    m = word_mismatches();
    tests_run++;
    if (m !== 0) begin
      tests_failed++;
      $display("[TB] FAIL multi_words: got %0d words (%0d bad) expected 60x3,58,62x4", got_data.size(), m);
    end
    tests_run++;
    if (first_valid !== first_accept + 1) begin
      tests_failed++;
      $display("[TB] FAIL multi_latency: got first valid cycle %0d expected %0d", first_valid, first_accept + 1);
    end
    tests_run++;
    if (done_seen !== 1 || got_used !== 3) begin
      tests_failed++;
      $display("[TB] FAIL multi_done: got done %0d tokens %0d expected 1 3", done_seen, got_used);
    end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL multi_done_pulse: got done %b expected 0", bus.done);
    end
  endtask

  task automatic test_zero_count();
    int m;
    logic [31:0] base;
    base = $urandom;
    tok_q = '{{4'd0, 28'd5}, {4'd8, 28'd61}};
    model_block(base);
    run_block(base);
    m = word_mismatches();
    tests_run++;
    if (m !== 0) begin
      tests_failed++;
      $display("[TB] FAIL zero_words: got %0d words (%0d bad) expected 8 of 61 from base", got_data.size(), m);
    end
    tests_run++;
    if (bus.err_zero !== 1'b1 || bus.err_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_flags: got zero %b ovf %b expected 1 0", bus.err_zero, bus.err_ovf);
    end
  endtask

  task automatic test_overflow();
    int m;
    logic [31:0] base;
    base = $urandom;
    tok_q = '{{4'd6, 28'd63}, {4'd5, 28'd59}, {4'd2, 28'd77}};
    model_block(base);
    run_block(base);
    m = word_mismatches();
    tests_run++;
    if (m !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_words: got %0d words (%0d bad) expected 63x6,59x2", got_data.size(), m);
    end
    tests_run++;
    if (bus.err_ovf !== 1'b1 || bus.err_zero !== 1'b0 || done_seen !== 1 || got_used !== 2) begin
      tests_failed++;
      $display("[TB] FAIL ovf_status: got ovf %b zero %b done %0d tokens %0d expected 1 0 1 2",
               bus.err_ovf, bus.err_zero, done_seen, got_used);
    end
    tok_q = '{{4'd8, 28'd1}};
    model_block(base);
    run_block(base);
    tests_run++;
    if (bus.err_ovf !== 1'b0 || bus.err_zero !== 1'b0 || word_mismatches() !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ovf_cleared: got ovf %b zero %b expected 0 0 and clean block", bus.err_ovf, bus.err_zero);
    end
  endtask

  task automatic test_addr_wrap();
    int m;
    tok_q = '{{4'd8, 28'd7}};
    model_block(32'hFFFF_FFFD);
    run_block(32'hFFFF_FFFD);
    m = word_mismatches();
    tests_run++;
    if (m !== 0) begin
      tests_failed++;
      $display("[TB] FAIL addr_wrap: got %0d words (%0d bad), last addr %h expected %h",
               got_data.size(), m, got_addr.size() > 0 ? got_addr[$] : 32'h0, 32'h0000_0004);
    end
  endtask

  task automatic test_back_to_back();
    int m;
    logic [31:0] base;
    ready_pct  = 50;
    valid_pct  = 60;
    spam_start = 1'b1;
    for (int b = 0; b < 6; b++) begin
      base = $urandom;
      gen_tokens();
      model_block(base);
      run_block(base);
      m = word_mismatches();
      tests_run++;
      if (m !== 0 || timed_out) begin
        tests_failed++;
        $display("[TB] FAIL bp_words[%0d]: got %0d words (%0d bad, timeout %b) expected %0d",
                 b, got_data.size(), m, timed_out, exp_data.size());
      end
      tests_run++;
      if (stab_err !== 0 || proto_err !== 0) begin
        tests_failed++;
        $display("[TB] FAIL bp_stable[%0d]: got %0d unstable, %0d ready-in-emit expected 0 0",
                 b, stab_err, proto_err);
      end
      tests_run++;
      if (bus.err_zero !== exp_zero || bus.err_ovf !== exp_ovf || got_used !== exp_used) begin
        tests_failed++;
        $display("[TB] FAIL bp_flags[%0d]: got zero %b ovf %b tokens %0d expected %b %b %0d",
                 b, bus.err_zero, bus.err_ovf, got_used, exp_zero, exp_ovf, exp_used);
      end
    end
    ready_pct  = 100;
    valid_pct  = 100;
    spam_start = 1'b0;
  endtask

  task automatic test_reset_midblock();
    int m;
    int dones;
    logic [31:0] base;
    base = $urandom;
    tok_q = '{{4'd8, 28'h123_4567}};
    abort_after = 3;
    run_block(base);
    abort_after = 0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.out_valid, bus.busy, bus.in_ready, bus.done} !== 4'b0 ||
        bus.out_data !== 32'h0 || bus.out_addr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got valid %b busy %b data %h addr %h expected all zero",
               bus.out_valid, bus.busy, bus.out_data, bus.out_addr);
    end
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (bus.done) dones++;
    tests_run++;
    if (dones !== 0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_idle: got dones %0d busy %b in_ready %b expected 0 0 0",
               dones, bus.busy, bus.in_ready);
    end
    base = $urandom;
    tok_q = '{{4'd2, 28'd9}, {4'd6, 28'd10}};
    model_block(base);
    run_block(base);
    m = word_mismatches();
    tests_run++;
    if (m !== 0 || done_seen !== 1 || bus.err_zero !== 1'b0 || bus.err_ovf !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_restart: got %0d words (%0d bad) done %0d expected clean 8-word block",
               got_data.size(), m, done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_multi_token();
    test_zero_count();
    test_overflow();
    test_addr_wrap();
    test_back_to_back();
    test_reset_midblock();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
